pb_rect_fill: RTL and testbench
===============================

# pb_rect_fill

Rectangle fill engine sitting directly upstream of the dual-port pixel buffer's write port. It accepts one solid-colour rectangle command at a time, clips it to the 160x120 frame, and issues one pixel write per clock in row-major order (PB_WA/PB_DATA/PB_WE). It replaces the switch/key manual write path and runs in the VGA clock domain, so no CDC is needed at the buffer.

## Interface

Parameters:
- FB_W, 160, frame width in pixels
- FB_H, 120, frame height in pixels
- AW, 15, pixel buffer address width
- DW, 4, pixel data width

Ports:
- VGA_CLK  input  1  VGA pixel clock, same clock as the pixel buffer
- VGA_RST  input  1  reset, asynchronous, active-high
- CMD_VALID  input  1  command present
- CMD_READY  output  1  engine can accept a command
- CMD_CLEAR  input  1  fill whole frame; X0/Y0/W/H ignored
- CMD_X0  input  8  left column
- CMD_Y0  input  7  top row
- CMD_W  input  8  width in pixels
- CMD_H  input  7  height in pixels
- CMD_COLOUR  input  DW  fill value
- PB_WA  output  AW  write address, linear y*FB_W+x
- PB_DATA  output  DW  write data
- PB_WE  output  1  write enable, one pixel per cycle high
- BUSY  output  1  command in progress (state != IDLE)
- DONE  output  1  one-cycle pulse at command completion

## Operation

- States: IDLE, SETUP, FILL, FIN.
- IDLE: CMD_READY=1 (combinational from state). Accept on rising edge with CMD_VALID&CMD_READY; latch all CMD_* fields. -> SETUP.
- SETUP (1 cycle): clip. If CMD_CLEAR: X0=0, Y0=0, W'=FB_W, H'=FB_H. Else W'=min(X0+W, FB_W)-X0, H'=min(Y0+H, FB_H)-Y0, computed at 9/8-bit width so no wrap; if X0>=FB_W or Y0>=FB_H or W==0 or H==0 then empty. Row base = Y0*FB_W+X0 (constant multiply). Empty -> FIN; else -> FILL.
- FILL: each cycle PB_WE=1, PB_WA=row base+column, PB_DATA=latched colour. Column counter 0..W'-1; at W'-1 column resets, row base += FB_W (add, no multiply), row counter increments. After the write of pixel (W'-1, H'-1) -> FIN.
- FIN (1 cycle): DONE=1, PB_WE=0. -> IDLE.
- CMD_VALID while not IDLE is ignored (not queued).
- PB_WA/PB_DATA/PB_WE are registered; PB_WA never exceeds FB_W*FB_H-1.

## Timing

- Reset values: PB_WA=0, PB_DATA=0, PB_WE=0, DONE=0, BUSY=0, state=IDLE (so CMD_READY=1).
- Accept edge = cycle N. SETUP in N+1. First PB_WE high in cycle N+2. Last write in cycle N+1+W'*H'. DONE high in cycle N+2+W'*H'. CMD_READY high again from N+3+W'*H'.
- Empty command: no PB_WE; DONE in cycle N+2; next accept earliest N+3.
- Throughput: exactly one write per cycle during FILL, no bubbles at row wrap.
- VGA_RST mid-operation: all outputs to reset values immediately (asynchronous), latched command discarded, no DONE issued; on release, engine in IDLE.
- Reads on the buffer's other port are unaffected; same-cycle read of a pixel being written returns the buffer's defined read-during-write value.

## Test plan

- Fill (10,5) W=2 H=2 colour 0xA -> PB_WE high 4 cycles from N+2, PB_WA 810,811,970,971, PB_DATA 0xA; DONE at N+6.
- Clip: (158,118) W=5 H=5 colour 0x3 -> exactly 4 writes, PB_WA 19038,19039,19198,19199; DONE at N+6.
- Empty: W=0 (and separately X0=160) -> PB_WE never high; DONE at N+2; CMD_READY high at N+3.
- CMD_CLEAR colour 0x0 -> 19200 consecutive writes, PB_WA 0..19199 monotonic, DONE at N+19202.
- VGA_RST asserted during FILL of a 10x10 command -> PB_WE=0 and BUSY=0 without waiting for an edge, no DONE; after release, new 1x1 at (0,0) writes PB_WA=0.
- CMD_VALID held high continuously with changing fields -> second command latched only at N+3+W'*H', fields as presented on that edge; no writes overlap.

Source files
------------

// File: rtl/pb_rect_fill.sv
// Solid-colour rectangle fill engine for the pixel buffer write port.
// Clips one command to the frame and writes one pixel per clock in row-major order.
module pb_rect_fill #(
    parameter int FB_W = 160,
    parameter int FB_H = 120,
    parameter int AW   = 15,
    parameter int DW   = 4
) (
    input  logic          VGA_CLK,
    input  logic          VGA_RST,
    input  logic          CMD_VALID,
    output logic          CMD_READY,
    input  logic          CMD_CLEAR,
    input  logic [7:0]    CMD_X0,
    input  logic [6:0]    CMD_Y0,
    input  logic [7:0]    CMD_W,
    input  logic [6:0]    CMD_H,
    input  logic [DW-1:0] CMD_COLOUR,
    output logic [AW-1:0] PB_WA,
    output logic [DW-1:0] PB_DATA,
    output logic          PB_WE,
    output logic          BUSY,
    output logic          DONE
);

    // Command handshake: a command transfers on the rising edge where
    // CMD_VALID and CMD_READY are both high; CMD_READY is high only in IDLE
    // and a command offered in any other state is dropped, not queued.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        FILL  = 2'd2,
        FIN   = 2'd3
    } state_t;

    localparam logic [8:0]    FB_W9 = 9'(FB_W);
    localparam logic [7:0]    FB_H8 = 8'(FB_H);
    localparam logic [AW-1:0] FB_WA = AW'(FB_W);

    state_t state;
    state_t next_state;

    // Latched command
    logic          cmd_clear;
    logic [7:0]    x0;
    logic [6:0]    y0;
    logic [7:0]    w;
    logic [6:0]    h;
    logic [DW-1:0] colour;

    // Clipped extent and fill counters
    logic [7:0]    fill_w;
    logic [6:0]    fill_h;
    logic [7:0]    col;
    logic [6:0]    row;
    logic [AW-1:0] row_base;

    // Clip arithmetic is one bit wider than the fields so x0+w cannot wrap.
    logic [8:0]    x_end;
    logic [8:0]    x_lim;
    logic [8:0]    clip_w;
    logic [7:0]    y_end;
    logic [7:0]    y_lim;
    logic [7:0]    clip_h;
    logic          empty;
    logic [7:0]    setup_w;
    logic [6:0]    setup_h;
    logic [AW-1:0] setup_base;
    logic          last_col;
    logic          last_row;

    always_comb begin
        x_end      = {1'b0, x0} + {1'b0, w};
        x_lim      = (x_end > FB_W9) ? FB_W9 : x_end;
        clip_w     = x_lim - {1'b0, x0};
        y_end      = {1'b0, y0} + {1'b0, h};
        y_lim      = (y_end > FB_H8) ? FB_H8 : y_end;
        clip_h     = y_lim - {1'b0, y0};
        empty      = !cmd_clear &&
                     (({1'b0, x0} >= FB_W9) || ({1'b0, y0} >= FB_H8) ||
                      (w == 8'd0) || (h == 7'd0));
        setup_w    = cmd_clear ? FB_W9[7:0] : clip_w[7:0];
        setup_h    = cmd_clear ? FB_H8[6:0] : clip_h[6:0];
        setup_base = cmd_clear ? '0 : (AW'(y0) * FB_WA) + AW'(x0);
        last_col   = (col == fill_w - 8'd1);
        last_row   = (row == fill_h - 7'd1);
    end

    always_ff @(posedge VGA_CLK or posedge VGA_RST) begin
        if (VGA_RST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (CMD_VALID) next_state = SETUP;
            SETUP:   next_state = empty ? FIN : FILL;
            FILL:    if (last_col && last_row) next_state = FIN;
            FIN:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign CMD_READY = (state == IDLE);
    assign BUSY      = (state != IDLE);
    assign DONE      = (state == FIN);

    always_ff @(posedge VGA_CLK or posedge VGA_RST) begin
        if (VGA_RST) begin
            cmd_clear <= 1'b0;
            x0        <= '0;
            y0        <= '0;
            w         <= '0;
            h         <= '0;
            colour    <= '0;
            fill_w    <= '0;
            fill_h    <= '0;
            col       <= '0;
            row       <= '0;
            row_base  <= '0;
            PB_WA     <= '0;
            PB_DATA   <= '0;
            PB_WE     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    PB_WE <= 1'b0;
                    if (CMD_VALID) begin
                        cmd_clear <= CMD_CLEAR;
                        x0        <= CMD_X0;
                        y0        <= CMD_Y0;
                        w         <= CMD_W;
                        h         <= CMD_H;
                        colour    <= CMD_COLOUR;
                    end
                end
                SETUP: begin
                    fill_w   <= setup_w;
                    fill_h   <= setup_h;
                    col      <= '0;
                    row      <= '0;
                    row_base <= setup_base;
                    PB_WA    <= setup_base;
                    PB_DATA  <= colour;
                    PB_WE    <= !empty;
                end
                FILL: begin
                    if (last_col && last_row) begin
                        PB_WE <= 1'b0;
                    end else if (last_col) begin
                        // Row wrap: step the base by one line, no bubble.
                        col      <= '0;
                        row      <= row + 7'd1;
                        row_base <= row_base + FB_WA;
                        PB_WA    <= row_base + FB_WA;
                    end else begin
                        col   <= col + 8'd1;
                        PB_WA <= PB_WA + AW'(1);
                    end
                end
                default: begin
                    PB_WE <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pb_rect_fill.sv
// Randomised scoreboard bench for pb_rect_fill: a pixel-list model predicts
// every write (cycle, address, data) and every DONE pulse.
module tb_pb_rect_fill;

    localparam int FB_W = 160;
    localparam int FB_H = 120;
    localparam int AW   = 15;
    localparam int DW   = 4;

    logic          VGA_CLK;
    logic          VGA_RST;
    logic          CMD_VALID;
    logic          CMD_READY;
    logic          CMD_CLEAR;
    logic [7:0]    CMD_X0;
    logic [6:0]    CMD_Y0;
    logic [7:0]    CMD_W;
    logic [6:0]    CMD_H;
    logic [DW-1:0] CMD_COLOUR;
    logic [AW-1:0] PB_WA;
    logic [DW-1:0] PB_DATA;
    logic          PB_WE;
    logic          BUSY;
    logic          DONE;

    pb_rect_fill #(.FB_W(FB_W), .FB_H(FB_H), .AW(AW), .DW(DW)) dut (
        .VGA_CLK(VGA_CLK), .VGA_RST(VGA_RST),
        .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_CLEAR(CMD_CLEAR),
        .CMD_X0(CMD_X0), .CMD_Y0(CMD_Y0), .CMD_W(CMD_W), .CMD_H(CMD_H),
        .CMD_COLOUR(CMD_COLOUR),
        .PB_WA(PB_WA), .PB_DATA(PB_DATA), .PB_WE(PB_WE),
        .BUSY(BUSY), .DONE(DONE)
    );

    // ---------------- clock / reset / cycle count ----------------
    initial VGA_CLK = 1'b0;
    always #5 VGA_CLK = ~VGA_CLK;

    int cyc = 0;
    always @(posedge VGA_CLK) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    // write entry: {cycle[31:0], address[14:0], data[3:0]}
    logic [50:0] exp_q[$];
    logic [31:0] exp_done_q[$];
    int          ready_cyc = 0;
    int          last_acc  = 0;
    int          n_checks  = 0;
    int          n_fail    = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: enumerate the requested rectangle's pixels in row-major
    // order, keep those inside the frame, one write per cycle from c+2.
    task automatic model_accept(input int c, input bit clr, input int x0, input int y0,
                                input int w, input int h, input int colour);
        int n;
        int xa;
        int ya;
        int ww;
        int hh;
        logic [31:0] t;
        logic [14:0] a;
        logic [3:0]  d;
        n  = 0;
        xa = clr ? 0 : x0;
        ya = clr ? 0 : y0;
        ww = clr ? FB_W : w;
        hh = clr ? FB_H : h;
        d  = 4'(colour);
        for (int y = ya; y < ya + hh; y++) begin
            for (int x = xa; x < xa + ww; x++) begin
                if (x < FB_W && y < FB_H) begin
                    t = 32'(c + 2 + n);
                    a = 15'(y * FB_W + x);
                    exp_q.push_back({t, a, d});
                    n++;
                end
            end
        end
        t = 32'(c + 2 + n);
        exp_done_q.push_back(t);
        ready_cyc = c + 3 + n;
        last_acc  = c;
    endtask

    // ---------------- monitor ----------------
    logic [50:0] got_w;
    logic [50:0] head_w;
    always @(negedge VGA_CLK) begin
        if (!VGA_RST) begin
            chk("cmd_ready", 64'(CMD_READY), 64'(cyc >= ready_cyc));
            chk("busy", 64'(BUSY), 64'(cyc < ready_cyc));
            if (PB_WE) begin
                got_w = {32'(cyc), PB_WA, PB_DATA};
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", 64'(got_w), 64'd0);
                end else begin
                    head_w = exp_q.pop_front();
                    chk("write", 64'(got_w), 64'(head_w));
                end
            end else if (exp_q.size() > 0 && int'(exp_q[0][50:19]) <= cyc) begin
                head_w = exp_q.pop_front();
                chk("missing_write", 64'(0), 64'(head_w));
            end
            if (DONE) begin
                if (exp_done_q.size() == 0) chk("unexpected_done", 64'(cyc), 64'hffff_ffff);
                else chk("done_cycle", 64'(cyc), 64'(exp_done_q.pop_front()));
            end else if (exp_done_q.size() > 0 && int'(exp_done_q[0]) <= cyc) begin
                chk("missing_done", 64'(0), 64'(exp_done_q.pop_front()));
            end
        end
    end

    // ---------------- driver tasks (entered/left at negedge+1) ----------------
    task automatic step();
        @(negedge VGA_CLK);
        #1;
    endtask

    task automatic send(input bit clr, input int x0, input int y0, input int w,
                        input int h, input int colour);
        CMD_VALID  = 1'b1;
        CMD_CLEAR  = clr;
        CMD_X0     = 8'(x0);
        CMD_Y0     = 7'(y0);
        CMD_W      = 8'(w);
        CMD_H      = 7'(h);
        CMD_COLOUR = 4'(colour);
        while (cyc < ready_cyc) step();
        model_accept(cyc, clr, x0 & 255, y0 & 127, w & 255, h & 127, colour & 15);
        step();
        CMD_VALID = 1'b0;
    endtask

    task automatic wait_idle();
        while (cyc < ready_cyc) step();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        VGA_RST    = 1'b1;
        CMD_VALID  = 1'b0;
        CMD_CLEAR  = 1'b0;
        CMD_X0     = '0;
        CMD_Y0     = '0;
        CMD_W      = '0;
        CMD_H      = '0;
        CMD_COLOUR = '0;
        repeat (3) @(negedge VGA_CLK);
        #1;
        chk("rst_we", 64'(PB_WE), 64'd0);
        chk("rst_wa", 64'(PB_WA), 64'd0);
        chk("rst_data", 64'(PB_DATA), 64'd0);
        chk("rst_done", 64'(DONE), 64'd0);
        chk("rst_busy", 64'(BUSY), 64'd0);
        chk("rst_ready", 64'(CMD_READY), 64'd1);
        VGA_RST = 1'b0;
        step();

        send(0, 10, 5, 2, 2, 4'hA);      // 810,811,970,971
        wait_idle();
        send(0, 158, 118, 5, 5, 4'h3);   // clipped to 2x2
        wait_idle();
        send(0, 20, 20, 0, 4, 4'h1);     // empty: W=0
        send(0, 160, 20, 4, 4, 4'h2);    // empty: X0 off-frame
        send(0, 5, 119, 3, 0, 4'h2);     // empty: H=0
        send(1, 77, 33, 9, 9, 4'h0);     // clear whole frame
        wait_idle();

        // Asynchronous reset in the middle of a 10x10 fill.
        send(0, 20, 20, 10, 10, 4'h7);
        while (cyc < last_acc + 17) step();
        #2;
        chk("fill_active", 64'(PB_WE), 64'd1);
        VGA_RST = 1'b1;
        exp_q.delete();
        exp_done_q.delete();
        ready_cyc = 0;
        #1;
        chk("arst_we", 64'(PB_WE), 64'd0);
        chk("arst_busy", 64'(BUSY), 64'd0);
        chk("arst_done", 64'(DONE), 64'd0);
        chk("arst_wa", 64'(PB_WA), 64'd0);
        chk("arst_ready", 64'(CMD_READY), 64'd1);
        @(negedge VGA_CLK);
        @(negedge VGA_CLK);
        #3;
        VGA_RST = 1'b0;
        step();
        send(0, 0, 0, 1, 1, 4'h5);       // single write at address 0
        wait_idle();

        // CMD_VALID held high with fields changing every cycle.
        CMD_VALID = 1'b1;
        CMD_CLEAR = 1'b0;
        for (int k = 0; k < 80; k++) begin
            int x;
            int y;
            int w;
            int h;
            int c;
            x = $urandom_range(0, 159);
            y = $urandom_range(0, 119);
            w = $urandom_range(1, 4);
            h = $urandom_range(1, 3);
            c = $urandom_range(0, 15);
            CMD_X0 = 8'(x); CMD_Y0 = 7'(y); CMD_W = 8'(w); CMD_H = 7'(h); CMD_COLOUR = 4'(c);
            if (cyc >= ready_cyc) model_accept(cyc, 0, x, y, w, h, c);
            step();
        end
        CMD_VALID = 1'b0;
        wait_idle();

        // Random commands, biased towards the frame edges.
        for (int i = 0; i < 60; i++) begin
            int x;
            int y;
            repeat ($urandom_range(0, 3)) step();
            x = ($urandom_range(0, 3) == 0) ? $urandom_range(150, 255) : $urandom_range(0, 159);
            y = ($urandom_range(0, 3) == 0) ? $urandom_range(110, 127) : $urandom_range(0, 119);
            send(0, x, y, $urandom_range(0, 12), $urandom_range(0, 8), $urandom_range(0, 15));
        end
        wait_idle();

        repeat (4) step();
        chk("write_queue_drained", 64'(exp_q.size()), 64'd0);
        chk("done_queue_drained", 64'(exp_done_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

endmodule
